// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory port, redirect port and decode handshake.
// master = fetch stage, slave = the memory/decode/execute environment around it.
interface instruction_fetch_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rd;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              fetch_done;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output fetch_done
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  fetch_done
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory and queues {pc, instr} in a 2-entry FIFO.
// Define IFETCH_WRAP_EN to loop back to RESET_PC after LAST_PC instead of stopping (fetch_done).
module instruction_fetch #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int LAST_PC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_PC);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic              done_q, done_d;
  entry_t            ent0_q, ent0_d;   // ent0 is always the queue head
  entry_t            ent1_q, ent1_d;
  entry_t            new_ent;
  logic              pop, push;

  always_comb begin
    pop     = (count_q != 2'd0) & bus.if_ready;
    push    = !bus.redirect_valid & !done_q & ((count_q != 2'd2) | pop);
    new_ent = '{pc: pc_q, instr: bus.imem_rd};
    pc_d    = pc_q;
    count_d = count_q;
    done_d  = done_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      count_d = 2'd0;
      done_d  = 1'b0;
    end else begin
      if (push) begin
        if (pc_q == LAST_A) begin
`ifdef IFETCH_WRAP_EN
          pc_d = RESET_A;
`else
          done_d = 1'b1;
`endif
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = new_ent;
          else                 ent1_d = new_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind the survivor.
          if (count_q == 2'd1) begin
            ent0_d = new_ent;
          end else begin
            ent0_d = ent1_q;
            ent1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_A;
      count_q <= 2'd0;
      done_q  <= 1'b0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      done_q  <= done_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count_q != 2'd0);
  assign bus.if_instr  = ent0_q.instr;
  assign bus.if_pc     = ent0_q.pc;
`ifdef IFETCH_WRAP_EN
  assign bus.fetch_done = 1'b0;
`else
  assign bus.fetch_done = done_q;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of `instruction_memory`. It owns the program counter, drives the memory address, and captures the returned 32-bit word together with its PC into a 2-entry queue. The queue feeds decode through a valid/ready handshake. A redirect port lets execute/branch logic flush the queue and restart fetch at a new address.

## Interface
- `ADDR_W`, 3, PC and memory address width (matches the 3-bit memory address).
- `DATA_W`, 32, instruction width.
- `RESET_PC`, 0, PC loaded on reset.
- `LAST_PC`, 4, highest valid instruction address (memory holds words 0..4).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  ADDR_W  address to memory; equals current PC.
- `imem_rd`  in  DATA_W  memory read data; combinational from `imem_addr`, same cycle.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDR_W  restart address.
- `if_valid`  out  1  queue head valid.
- `if_ready`  in  1  decode accepts head.
- `if_instr`  out  DATA_W  head instruction.
- `if_pc`  out  ADDR_W  head PC.
- `fetch_done`  out  1  fetch stopped at end of program (non-wrap build only).

## Operation
- State: `pc`, 2-entry FIFO of {pc, instr}, 2-bit `count` (0..2), `done` flag.
- pop = `if_valid & if_ready`.
- push = `!redirect_valid & !done & (count<2 | pop)`. On push, the FIFO stores {`pc`, `imem_rd`}.
- On push, `pc` advances:
  - If `pc==LAST_PC`, end-of-program rule applies (see Configuration).
  - Otherwise `pc+1`, modulo 2^ADDR_W.
- `count` next = count + push − pop. Push and pop in the same cycle with `count==2` is legal; the new entry takes the freed slot.
- Redirect has highest priority:
  - `pc` is loaded from `redirect_pc`.
  - `count` is set to 0 and `done` is cleared.
  - No push occurs that cycle.
  - A pop in the same cycle counts as consumed by decode, but the queue is cleared regardless.
- `if_valid = (count!=0)`. `if_instr` and `if_pc` show the head entry; they are don't-care while `if_valid=0`.
- While `if_valid=1 & !if_ready`, `if_instr` and `if_pc` must stay stable.
- `imem_addr = pc` at all times, including while stalled or done.

## Timing
- Reset (async assert) values:
  - `pc=RESET_PC`, `count=0`, `done=0`.
  - `if_valid=0`, `if_instr=0`, `if_pc=0`, `fetch_done=0`.
- Latency: the word at PC p is pushed at the edge where `pc==p`, and shows on `if_valid` in the following cycle. So fetch-to-decode latency is 1 cycle.
- After reset release, the first rising edge pushes `RESET_PC`, and `if_valid=1` from then on.
- Redirect sampled at edge N:
  - `if_valid=0` after N.
  - The target instruction is valid after edge N+1.
- Throughput: with `if_ready` held high, one instruction per cycle.
- Backpressure: with `if_ready` held low, the queue fills after 2 pushes, then `pc` freezes.
- Reset asserted mid-operation clears the queue immediately; in-flight entries are lost.

## Configuration
- Macro: `IFETCH_WRAP_EN`.
- Defined:
  - A push at `pc==LAST_PC` sets `pc` to `RESET_PC`, so fetch loops forever.
  - `fetch_done` is tied to 0.
- Undefined:
  - A push at `pc==LAST_PC` sets `done=1` and leaves `pc` at `LAST_PC`.
  - No further pushes occur, but queued entries still drain.
  - `fetch_done` follows `done`.
  - Only a redirect or reset clears `done`.

## Test plan
- Streaming: memory model returns `0xA0000000|addr`, `if_ready=1`, non-wrap build. Expect `if_instr` 0xA0000000..0xA0000004 on consecutive cycles with `if_pc` 0..4, then `fetch_done=1` and `if_valid=0` one cycle after the last pop.
- Backpressure: `if_ready=0` after reset. Expect `count` reaches 2 holding PCs 0 and 1, `imem_addr` stays at 2, and the head is stable. Raise `if_ready` to 1 and expect PCs 0,1,2,... in order with no loss or duplication.
- Full + simultaneous push/pop: `count==2`, `if_ready=1` for one cycle. Expect PC 0 to pop, PC 2 to enter, and `count` to stay at 2.
- Redirect: after PC 1 is queued, pulse `redirect_valid` with `redirect_pc=3`. Expect `if_valid=0` next cycle, then `if_pc=3` with `if_instr=0xA0000003`. In the non-wrap build, redirect while `fetch_done=1` clears it.
- Wrap build (`IFETCH_WRAP_EN`): stream 7 instructions. Expect `if_pc` sequence 0,1,2,3,4,0,1 and `fetch_done` stays 0.
- Reset mid-stream: assert `rst=0` while `count==2`. Expect `if_valid=0` and `imem_addr=0` asynchronously. After release, fetch resumes from PC 0.
